// File: rtl/led_seq_pkg.sv
// Shared types and the default LED pattern table for the LED sequencer.
// Swap SEQ_TABLE (or the ROM) per board; the FSM does not depend on its contents.
package led_seq_pkg;

  localparam int MS_W  = 10;
  localparam int PAT_W = 4;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [MS_W-1:0]  durMs;
  } step_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELEASE
  } state_t;

  localparam step_t SEQ_TABLE [16] = '{
    '{4'b0001, 10'd5},   '{4'b0010, 10'd3},   '{4'b0100, 10'd0},   '{4'b1000, 10'd20},
    '{4'b0011, 10'd10},  '{4'b0110, 10'd10},  '{4'b1100, 10'd10},  '{4'b1001, 10'd50},
    '{4'b1111, 10'd100}, '{4'b0000, 10'd100}, '{4'b0101, 10'd25},  '{4'b1010, 10'd25},
    '{4'b0111, 10'd40},  '{4'b1110, 10'd40},  '{4'b1011, 10'd40},  '{4'b1101, 10'd40}
  };

endpackage

// File: rtl/led_seq_rom.sv
// Combinational step-table lookup: index -> {pattern, duration}.
// Zero latency; no flow control.
module led_seq_rom
  import led_seq_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output step_t            step
);

  assign step = SEQ_TABLE[idx];

endmodule

// File: rtl/led_sequencer.sv
// Steps through the LED pattern table, driving the ms timer and advancing on its timeout.
// Outputs registered, one clk after the triggering input; start/stop are level-sampled, no backpressure.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int LED_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loopMode,
  input  logic             timeout,
  output logic             enable,
  output logic [MS_W-1:0]  delayInMs,
  output logic [LED_W-1:0] leds,
  output logic [IDX_W-1:0] stepIdx,
  output logic             busy,
  output logic             done
);

  if (NUM_STEPS < 1 || NUM_STEPS > 16) begin : g_bad_num_steps
    $error("led_sequencer: NUM_STEPS must be in 1..16");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_t             state, state_n;
  logic               stop_req, stop_req_n;
  logic               enable_n, busy_n, done_n;
  logic [MS_W-1:0]    delay_n;
  logic [LED_W-1:0]   leds_n;
  logic [IDX_W-1:0]   step_n, next_idx, rom_idx;
  step_t              rom_step;

  assign next_idx = (stepIdx == LAST_IDX) ? '0 : stepIdx + 4'd1;
  // From IDLE the lookup always targets entry 0; in RUN it pre-fetches the next entry.
  assign rom_idx  = (state == RUN) ? next_idx : '0;

  led_seq_rom u_rom (
    .idx  (rom_idx),
    .step (rom_step)
  );

  always_comb begin
    state_n    = state;
    stop_req_n = stop_req;
    enable_n   = enable;
    delay_n    = delayInMs;
    leds_n     = leds;
    step_n     = stepIdx;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n  = RUN;
          step_n   = '0;
          leds_n   = LED_W'(rom_step.pattern);
          delay_n  = rom_step.durMs;
          enable_n = 1'b1;
          busy_n   = 1'b1;
        end
      end
      RUN: begin
        if (stop) stop_req_n = 1'b1;
        if (timeout) begin
          if (stop_req || (stepIdx == LAST_IDX && !loopMode)) begin
            state_n = RELEASE;
          end else begin
            step_n  = next_idx;
            leds_n  = LED_W'(rom_step.pattern);
            delay_n = rom_step.durMs;
          end
        end
      end
      RELEASE: begin
        // enable held high through this cycle so the timer drops its load flag cleanly
        state_n    = IDLE;
        enable_n   = 1'b0;
        leds_n     = '0;
        busy_n     = 1'b0;
        done_n     = 1'b1;
        stop_req_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stop_req  <= 1'b0;
      enable    <= 1'b0;
      delayInMs <= '0;
      leds      <= '0;
      stepIdx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      stop_req  <= stop_req_n;
      enable    <= enable_n;
      delayInMs <= delay_n;
      leds      <= leds_n;
      stepIdx   <= step_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule
